// File: rtl/cpu_types_pkg.sv
// Shared MIPS pipeline types: machine word, fetch FSM states, instruction byte width.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t WBYTES = 32'd4;

    function automatic word_t next_pc(input word_t pc);
        return pc + WBYTES;
    endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register holding the instruction, its PC+4 and a valid flag.
// Latency: one cycle from load to outputs.
// Backpressure: holds contents whenever no control is asserted.
module fetch_ifid_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  bubble,
    input  logic  flush,
    input  word_t load_instr,
    input  word_t load_npc,
    output word_t instr,
    output word_t npc,
    output logic  instr_valid
);

    // flush clears everything; bubble keeps npc so decode sees a clean NOP slot
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            instr       <= '0;
            npc         <= '0;
            instr_valid <= 1'b0;
        end else if (bubble) begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if (load) begin
            instr       <= load_instr;
            npc         <= load_npc;
            instr_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem request, one-entry hold buffer, IF/ID register, delivery counter.
// Latency: instruction on instr one cycle after the edge with ihit (one instruction per cycle).
// Backpressure: stall parks a hit in the hold buffer and suspends requests until released.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
)(
    input  logic  CLK,
    input  logic  RST,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t instr,
    output word_t npc,
    output logic  instr_valid,
    output word_t fetch_count
);

    fetch_state_t state;
    word_t        pc;
    word_t        hbuf_instr;
    word_t        hbuf_npc;

    logic  active;
    logic  ifid_load;
    logic  ifid_bubble;
    logic  ifid_flush;
    word_t ifid_instr;
    word_t ifid_npc;

    assign imemREN  = (state == FETCH) && !RST;
    assign imemaddr = pc;

    assign active      = (state != HALTED);
    assign ifid_flush  = active && redirect;
    assign ifid_bubble = active && !redirect &&
                         (halt || ((state == FETCH) && !ihit && !stall));
    assign ifid_load   = active && !redirect && !halt &&
                         (((state == FETCH) && ihit && !stall) ||
                          ((state == HOLD) && !stall));
    assign ifid_instr  = (state == HOLD) ? hbuf_instr : imemload;
    assign ifid_npc    = (state == HOLD) ? hbuf_npc   : next_pc(pc);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            hbuf_instr  <= '0;
            hbuf_npc    <= '0;
            fetch_count <= '0;
        end else if (active) begin
            if (redirect) begin
                state      <= FETCH;
                pc         <= {redirect_pc[31:2], 2'b00};
                hbuf_instr <= '0;
                hbuf_npc   <= '0;
            end else if (halt) begin
                state <= HALTED;
            end else if (state == FETCH) begin
                if (ihit) begin
                    pc <= next_pc(pc);
                    if (stall) begin
                        hbuf_instr <= imemload;
                        hbuf_npc   <= next_pc(pc);
                        state      <= HOLD;
                    end else begin
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
            end else if (!stall) begin
                // pc already points past the buffered word, so requests resume without refetch
                fetch_count <= fetch_count + 32'd1;
                state       <= FETCH;
            end
        end
    end

    fetch_ifid_reg u_ifid (
        .CLK         (CLK),
        .RST         (RST),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .flush       (ifid_flush),
        .load_instr  (ifid_instr),
        .load_npc    (ifid_npc),
        .instr       (instr),
        .npc         (npc),
        .instr_valid (instr_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference model plus queue of in-flight fetched words.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam word_t PC_INIT = 32'h0000_0000;
    localparam word_t XORPAT  = 32'hA5A5_0000;

    logic  CLK = 1'b0;
    logic  RST = 1'b1;
    logic  imemREN;
    word_t imemaddr;
    logic  ihit = 1'b0;
    word_t imemload = '0;
    logic  stall = 1'b0;
    logic  redirect = 1'b0;
    word_t redirect_pc = '0;
    logic  halt = 1'b0;
    word_t instr;
    word_t npc;
    logic  instr_valid;
    word_t fetch_count;

    always #5 CLK = ~CLK;

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .ihit        (ihit),
        .imemload    (imemload),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr       (instr),
        .npc         (npc),
        .instr_valid (instr_valid),
        .fetch_count (fetch_count)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input word_t act, input word_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // reference model state
    fetch_state_t   mst;
    word_t          mpc, mcnt, minstr, mnpc;
    logic           mvalid;
    logic [63:0]    sb[$];

    task automatic model_reset();
        mst = FETCH; mpc = PC_INIT; mcnt = '0;
        minstr = '0; mnpc = '0; mvalid = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        @(posedge CLK); #1;
        model_reset();
        chk("rst_ren",   {31'd0, imemREN}, 32'd0);
        chk("rst_addr",  imemaddr, PC_INIT);
        chk("rst_instr", instr, 32'd0);
        chk("rst_npc",   npc, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_cnt",   fetch_count, 32'd0);
        RST = 1'b0;
    endtask

    task automatic step(input logic h, input logic s, input logic r,
                        input word_t rpc, input logic hl);
        logic        deliver;
        logic [63:0] ent;
        ihit = h; stall = s; redirect = r; redirect_pc = rpc; halt = hl;
        imemload = mpc ^ XORPAT;
        #1;
        chk("addr", imemaddr, mpc);
        chk("ren",  {31'd0, imemREN}, {31'd0, mst == FETCH});
        deliver = 1'b0;
        if (mst != HALTED) begin
            if (r) begin
                sb.delete();
                mpc = {rpc[31:2], 2'b00};
                mst = FETCH; mvalid = 1'b0; minstr = '0; mnpc = '0;
            end else if (hl) begin
                sb.delete();
                mst = HALTED; mvalid = 1'b0; minstr = '0;
            end else if (mst == FETCH) begin
                if (h) begin
                    sb.push_back({mpc ^ XORPAT, mpc + 32'd4});
                    mpc = mpc + 32'd4;
                    if (s) mst = HOLD;
                    else   deliver = 1'b1;
                end else if (!s) begin
                    mvalid = 1'b0; minstr = '0;
                end
            end else if (!s) begin
                deliver = 1'b1; mst = FETCH;
            end
        end
        @(posedge CLK); #1;
        ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        if (deliver) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                ent = sb.pop_front();
                minstr = ent[63:32]; mnpc = ent[31:0]; mvalid = 1'b1;
                mcnt = mcnt + 32'd1;
            end
        end
        chk("instr", instr, minstr);
        chk("npc",   npc, mnpc);
        chk("valid", {31'd0, instr_valid}, {31'd0, mvalid});
        chk("count", fetch_count, mcnt);
    endtask

    initial begin
        do_reset();

        // back-to-back zero-wait fetch from PC_INIT
        repeat (3) step(1, 0, 0, '0, 0);
        chk("cnt3", fetch_count, 32'd3);
        chk("npc3", npc, 32'd12);

        // wait states at 0x10
        step(0, 0, 1, 32'h10, 0);
        repeat (3) step(0, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        chk("wait_npc", npc, 32'h14);

        // stall during hit at 0x20, held 4 cycles, then released
        step(0, 0, 1, 32'h20, 0);
        step(1, 1, 0, '0, 0);
        repeat (3) step(0, 1, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        chk("hold_npc", npc, 32'h24);
        step(1, 0, 0, '0, 0);

        // redirect beats stall, ihit and halt; low bits of target dropped
        step(1, 1, 1, 32'h103, 1);
        chk("redir_addr", imemaddr, 32'h100);
        step(1, 0, 0, '0, 0);

        // redirect out of HOLD discards the buffered word
        step(1, 1, 0, '0, 0);
        step(0, 1, 1, 32'h200, 0);
        step(1, 0, 0, '0, 0);

        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, '0, 0);
        chk("wrap_npc", npc, 32'h0);
        step(1, 0, 0, '0, 0);

        // halt at 0x40 with a same-cycle hit; redirect cannot wake it
        step(0, 0, 1, 32'h40, 0);
        step(1, 0, 0, '0, 1);
        repeat (3) step(1, 0, 0, '0, 0);
        step(1, 0, 1, 32'h80, 0);
        chk("halt_addr", imemaddr, 32'h40);

        // reset while in HOLD
        do_reset();
        step(1, 1, 0, '0, 0);
        do_reset();
        step(1, 0, 0, '0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
